l2_responder_controller: RTL and testbench
==========================================

// Module: l2_responder_controller
// PURPOSE
//  L2-side controller answering L1 line requests (read_L1_L2 / write_L1_L2, acked by ready_L2_L1).
//  Direct-mapped, write-back L2 with tag/valid/dirty tracking.
//  Issues line fetches and write-backs to memory; drives strobes for the L2 data array (separate block).
// PARAMETERS
//  BLK_W  26  L1 block address width ({tag,index} from L1, no offset)
//  IDX_W  8   L2 index bits (256 sets); L2 tag width = BLK_W-IDX_W = 18
// PORTS
//  clk           in   1      clock, all logic on posedge
//  rst           in   1      async active-high reset
//  read_L1_L2    in   1      L1 read-line request, level, held until ready_L2_L1
//  write_L1_L2   in   1      L1 write-back-line request, level, held until ready_L2_L1
//  blk_addr      in   BLK_W  request block address, stable while request high
//  ready_L2_L1   out  1      one-cycle completion pulse to L1
//  busy          out  1      state != S_IDLE
//  read_L2_MEM   out  1      memory line fetch, level, until ready_MEM_L2
//  write_L2_MEM  out  1      memory line write-back, level, until ready_MEM_L2
//  mem_addr      out  BLK_W  victim addr in write-back, request addr in allocate, else 0
//  ready_MEM_L2  in   1      one-cycle memory completion pulse
//  refill_L2     out  1      data array: write line from memory at req index
//  update_L2     out  1      data array: write line from L1 at req index
//  data_rd_L2    out  1      data array: read line at req index (to L1 or to memory)
// BEHAVIOUR
//  Reset: state S_IDLE; all outputs 0; valid/dirty/tag all 0. Reset mid-transaction aborts it, no ack.
//  States: S_IDLE, S_COMPARE, S_WRITE_BACK, S_ALLOCATE, S_RESPOND.
//  S_IDLE: if write_L1_L2 or read_L1_L2, latch blk_addr and op (write wins if both) -> S_COMPARE.
//  S_COMPARE (1 cycle, comb. hit = valid[idx] && tag==TAG[idx]):
//    hit -> S_RESPOND. Miss with valid&dirty victim -> S_WRITE_BACK.
//    Read miss, clean/invalid victim -> S_ALLOCATE. Write miss, clean/invalid victim -> S_RESPOND (no fetch, full line).
//  S_WRITE_BACK: write_L2_MEM=1, data_rd_L2=1, mem_addr={TAG[idx],idx}. On ready_MEM_L2: dirty[idx]<=0;
//    read -> S_ALLOCATE, write -> S_RESPOND.
//  S_ALLOCATE: read_L2_MEM=1, mem_addr=latched addr. On ready_MEM_L2 (same cycle): refill_L2=1,
//    TAG<=tag, valid<=1, dirty<=0 -> S_RESPOND.
//  S_RESPOND (1 cycle): ready_L2_L1=1. Read: data_rd_L2=1.
//    Write: update_L2=1, TAG<=tag, valid<=1, dirty<=1. -> S_IDLE.
//  Latency from the request-sampling edge:
//    Read hit: ready high 2 cycles later.
//    Misses add (cycles until each ready_MEM_L2) + 1 per memory phase.
//  Request dropped before ack: ignored; transaction completes, ack still pulses.
//  ready_MEM_L2 outside S_WRITE_BACK/S_ALLOCATE: ignored.
//  Back-to-back: the cycle after S_RESPOND is S_IDLE, which may accept a new request.
//  Index = addr[IDX_W-1:0]; tag = addr[BLK_W-1:IDX_W]. Index 0 and 255 are legal sets; no wrap logic.
// STRUCTURE
//  l2_defs.vh: state localparams, BLK_W/IDX_W defaults.
//  Sub-module l2_tag_array: tag/valid/dirty storage.
//    Comb read port; one write port with set/clear of valid/dirty.
//    Async reset clears all.
// TESTING
//  1. Cold read, addr 0x000_0012, memory acks after 3 cycles:
//     read_L2_MEM held 3 cycles, mem_addr=0x12, refill_L2 pulses, ready_L2_L1 one pulse, no write_L2_MEM.
//  2. Repeat read 0x12: hit, ready_L2_L1 2 cycles after sampling edge, read_L2_MEM never asserted.
//  3. Write 0x100_0012 (same set, other tag):
//     clean victim -> no memory traffic; update_L2 + ack in S_RESPOND; dirty[0x12]=1.
//  4. Read 0x200_0012: write_L2_MEM with mem_addr=0x100_0012 first, then read_L2_MEM mem_addr=0x200_0012, one ack.
//  5. read & write high together on 0x34: treated as write (update_L2=1, refill_L2=0).
//  6. rst pulsed during S_ALLOCATE: outputs 0 next cycle, no ack.
//     Re-read of the same addr misses (valid cleared).

Source files
------------

// File: rtl/l2_responder_controller_pkg.sv
// Shared widths, types and address helpers for the L2 responder controller.
package l2_responder_controller_pkg;

    localparam int unsigned BLK_W = 26;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned TAG_W = BLK_W - IDX_W;
    localparam int unsigned SETS  = 1 << IDX_W;

    typedef logic [BLK_W-1:0] blk_addr_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITE_BACK,
        S_ALLOCATE,
        S_RESPOND
    } state_t;

    // One write into the tag/valid/dirty store; tag is only written when tag_en is set.
    typedef struct packed {
        logic wr_en;
        idx_t idx;
        logic tag_en;
        tag_t tag;
        logic valid;
        logic dirty;
    } tag_wr_t;

    function automatic idx_t addr_idx(input blk_addr_t a);
        return a[IDX_W-1:0];
    endfunction

    function automatic tag_t addr_tag(input blk_addr_t a);
        return a[BLK_W-1:IDX_W];
    endfunction

endpackage

// File: rtl/l2_responder_controller_if.sv
// L1 request, memory request and data-array strobe bundle of the L2 controller.
interface l2_responder_controller_if;

    logic                                   read_L1_L2;
    logic                                   write_L1_L2;
    l2_responder_controller_pkg::blk_addr_t blk_addr;
    logic                                   ready_L2_L1;
    logic                                   busy;
    logic                                   read_L2_MEM;
    logic                                   write_L2_MEM;
    l2_responder_controller_pkg::blk_addr_t mem_addr;
    logic                                   ready_MEM_L2;
    logic                                   refill_L2;
    logic                                   update_L2;
    logic                                   data_rd_L2;

    // Controller side
    modport slave (
        input  read_L1_L2, write_L1_L2, blk_addr, ready_MEM_L2,
        output ready_L2_L1, busy, read_L2_MEM, write_L2_MEM, mem_addr,
               refill_L2, update_L2, data_rd_L2
    );

    // Environment side (L1, memory, data array)
    modport master (
        output read_L1_L2, write_L1_L2, blk_addr, ready_MEM_L2,
        input  ready_L2_L1, busy, read_L2_MEM, write_L2_MEM, mem_addr,
               refill_L2, update_L2, data_rd_L2
    );

endinterface

// File: rtl/l2_responder_controller_tag_array.sv
// Tag/valid/dirty storage for the direct-mapped L2: combinational read, single write port.
module l2_responder_controller_tag_array
    import l2_responder_controller_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  idx_t    rd_idx,
    output tag_t    rd_tag,
    output logic    rd_valid,
    output logic    rd_dirty,
    input  tag_wr_t wr
);

    tag_t            tag_q [SETS];
    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] dirty_q;

    // Storage update; reset invalidates every set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '{default: '0};
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr.wr_en) begin
            if (wr.tag_en) begin
                tag_q[wr.idx] <= wr.tag;
            end
            valid_q[wr.idx] <= wr.valid;
            dirty_q[wr.idx] <= wr.dirty;
        end
    end

    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];

endmodule

// File: rtl/l2_responder_controller.sv
// Direct-mapped write-back L2 controller: answers L1 line requests, fetches and writes back lines.
module l2_responder_controller
    import l2_responder_controller_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    l2_responder_controller_if.slave l2
);

    state_t    state;
    blk_addr_t req_addr;
    logic      req_write;

    idx_t      req_idx;
    tag_t      req_tag;
    tag_t      vic_tag;
    logic      vic_valid;
    logic      vic_dirty;
    logic      hit_c;
    tag_wr_t   tag_wr_c;

    assign req_idx = addr_idx(req_addr);
    assign req_tag = addr_tag(req_addr);

    l2_responder_controller_tag_array u_tag_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_tag   (vic_tag),
        .rd_valid (vic_valid),
        .rd_dirty (vic_dirty),
        .wr       (tag_wr_c)
    );

    assign hit_c = vic_valid && (vic_tag == req_tag);

    // Refill strobe must coincide with the memory data beat, so it follows ready_MEM_L2 directly
    assign l2.refill_L2 = (state == S_ALLOCATE) && l2.ready_MEM_L2;

    // Tag store updates: clean after write-back, install on refill, install dirty on L1 write
    always_comb begin
        tag_wr_c     = '0;
        tag_wr_c.idx = req_idx;
        tag_wr_c.tag = req_tag;
        unique case (state)
            S_WRITE_BACK: begin
                if (l2.ready_MEM_L2) begin
                    tag_wr_c.wr_en = 1'b1;
                    tag_wr_c.valid = 1'b1;
                end
            end
            S_ALLOCATE: begin
                if (l2.ready_MEM_L2) begin
                    tag_wr_c.wr_en  = 1'b1;
                    tag_wr_c.tag_en = 1'b1;
                    tag_wr_c.valid  = 1'b1;
                end
            end
            S_RESPOND: begin
                if (req_write) begin
                    tag_wr_c.wr_en  = 1'b1;
                    tag_wr_c.tag_en = 1'b1;
                    tag_wr_c.valid  = 1'b1;
                    tag_wr_c.dirty  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Controller FSM; outputs are registered as a function of the state being entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            req_addr        <= '0;
            req_write       <= 1'b0;
            l2.ready_L2_L1  <= 1'b0;
            l2.busy         <= 1'b0;
            l2.read_L2_MEM  <= 1'b0;
            l2.write_L2_MEM <= 1'b0;
            l2.mem_addr     <= '0;
            l2.update_L2    <= 1'b0;
            l2.data_rd_L2   <= 1'b0;
        end else begin
            l2.ready_L2_L1  <= 1'b0;
            l2.busy         <= 1'b1;
            l2.read_L2_MEM  <= 1'b0;
            l2.write_L2_MEM <= 1'b0;
            l2.mem_addr     <= '0;
            l2.update_L2    <= 1'b0;
            l2.data_rd_L2   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (l2.write_L1_L2 || l2.read_L1_L2) begin
                        req_addr  <= l2.blk_addr;
                        req_write <= l2.write_L1_L2;
                        state     <= S_COMPARE;
                    end else begin
                        l2.busy <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (!hit_c && vic_valid && vic_dirty) begin
                        state           <= S_WRITE_BACK;
                        l2.write_L2_MEM <= 1'b1;
                        l2.data_rd_L2   <= 1'b1;
                        l2.mem_addr     <= {vic_tag, req_idx};
                    end else if (!hit_c && !req_write) begin
                        state          <= S_ALLOCATE;
                        l2.read_L2_MEM <= 1'b1;
                        l2.mem_addr    <= req_addr;
                    end else begin
                        // Hit, or write miss over a clean/invalid victim (full line, no fetch)
                        state          <= S_RESPOND;
                        l2.ready_L2_L1 <= 1'b1;
                        l2.data_rd_L2  <= !req_write;
                        l2.update_L2   <= req_write;
                    end
                end
                S_WRITE_BACK: begin
                    if (l2.ready_MEM_L2 && req_write) begin
                        state          <= S_RESPOND;
                        l2.ready_L2_L1 <= 1'b1;
                        l2.update_L2   <= 1'b1;
                    end else if (l2.ready_MEM_L2) begin
                        state          <= S_ALLOCATE;
                        l2.read_L2_MEM <= 1'b1;
                        l2.mem_addr    <= req_addr;
                    end else begin
                        l2.write_L2_MEM <= 1'b1;
                        l2.data_rd_L2   <= 1'b1;
                        l2.mem_addr     <= {vic_tag, req_idx};
                    end
                end
                S_ALLOCATE: begin
                    if (l2.ready_MEM_L2) begin
                        state          <= S_RESPOND;
                        l2.ready_L2_L1 <= 1'b1;
                        l2.data_rd_L2  <= 1'b1;
                    end else begin
                        l2.read_L2_MEM <= 1'b1;
                        l2.mem_addr    <= req_addr;
                    end
                end
                S_RESPOND: begin
                    state   <= S_IDLE;
                    l2.busy <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    l2.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_responder_controller.sv
// Directed, table-driven bench for l2_responder_controller with a simple memory responder.
module tb_l2_responder_controller;
    import l2_responder_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    l2_responder_controller_if l2 ();

    l2_responder_controller dut (
        .clk (clk),
        .rst (rst),
        .l2  (l2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic      rd;
        logic      wr;
        blk_addr_t addr;
        int        delay;   // memory ack arrives in the delay-th cycle a memory request is high
        bit        drop;    // withdraw the L1 request right after it is sampled
        int        ack;     // cycle (edges after sampling edge inclusive) where ready_L2_L1 is seen
        int        rdc;     // cycles read_L2_MEM high
        int        wrc;     // cycles write_L2_MEM high
        blk_addr_t rda;     // mem_addr during read_L2_MEM
        blk_addr_t wra;     // mem_addr during write_L2_MEM
        int        refc;    // refill_L2 pulses
        int        updc;    // update_L2 pulses
        int        drc;     // data_rd_L2 cycles
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input blk_addr_t addr,
                                input int delay, input bit drop, input int ack,
                                input int rdc, input int wrc, input blk_addr_t rda,
                                input blk_addr_t wra, input int refc, input int updc,
                                input int drc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.delay = delay; v.drop = drop;
        v.ack = ack; v.rdc = rdc; v.wrc = wrc; v.rda = rda; v.wra = wra;
        v.refc = refc; v.updc = updc; v.drc = drc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({l2.busy, l2.ready_L2_L1, l2.read_L2_MEM, l2.write_L2_MEM,
                    l2.refill_L2, l2.update_L2, l2.data_rd_L2, l2.mem_addr});
    endfunction

    // Apply one L1 request, play memory, and compare everything observed against the record
    task automatic run(input int id, input vec_t v);
        int        ack_cyc = -1;
        int        acks = 0, rdc = 0, wrc = 0, refc = 0, updc = 0, drc = 0;
        int        busy_bad = 0, hi = 0;
        blk_addr_t rda = '0, wra = '0;
        bit        done = 1'b0;
        l2.read_L1_L2  = v.rd;
        l2.write_L1_L2 = v.wr;
        l2.blk_addr    = v.addr;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(posedge clk);
            #1;
            if (v.drop && k == 1) begin
                l2.read_L1_L2  = 1'b0;
                l2.write_L1_L2 = 1'b0;
            end
            if (!l2.busy) busy_bad++;
            if (l2.read_L2_MEM) begin rdc++; rda = l2.mem_addr; end
            if (l2.write_L2_MEM) begin wrc++; wra = l2.mem_addr; end
            if (l2.update_L2) updc++;
            if (l2.data_rd_L2) drc++;
            if (l2.read_L2_MEM || l2.write_L2_MEM) begin
                hi++;
                if (hi >= v.delay) begin
                    l2.ready_MEM_L2 = 1'b1;
                    hi = 0;
                end else begin
                    l2.ready_MEM_L2 = 1'b0;
                end
            end else begin
                l2.ready_MEM_L2 = 1'b0;
            end
            #1;
            if (l2.refill_L2) refc++;
            if (l2.ready_L2_L1) begin
                acks++;
                ack_cyc = k;
                done = 1'b1;
                l2.read_L1_L2  = 1'b0;
                l2.write_L1_L2 = 1'b0;
            end
        end
        l2.ready_MEM_L2 = 1'b0;
        chk($sformatf("v%0d ack_cycle", id), 64'(ack_cyc), 64'(v.ack));
        chk($sformatf("v%0d ack_count", id), 64'(acks), 64'd1);
        chk($sformatf("v%0d busy_low_in_txn", id), 64'(busy_bad), 64'd0);
        chk($sformatf("v%0d read_mem_cycles", id), 64'(rdc), 64'(v.rdc));
        chk($sformatf("v%0d write_mem_cycles", id), 64'(wrc), 64'(v.wrc));
        chk($sformatf("v%0d read_mem_addr", id), 64'(rda), 64'(v.rda));
        chk($sformatf("v%0d write_mem_addr", id), 64'(wra), 64'(v.wra));
        chk($sformatf("v%0d refill_pulses", id), 64'(refc), 64'(v.refc));
        chk($sformatf("v%0d update_pulses", id), 64'(updc), 64'(v.updc));
        chk($sformatf("v%0d data_rd_cycles", id), 64'(drc), 64'(v.drc));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d idle_after", id), all_outs(), 64'd0);
    endtask

    initial begin
        vec_t tbl[12];
        bit   found;
        int   stray;

        tbl[0]  = mk(1, 0, 26'h0000012, 3, 0, 5, 3, 0, 26'h0000012, 26'h0, 1, 0, 1); // cold read
        tbl[1]  = mk(1, 0, 26'h0000012, 3, 0, 2, 0, 0, 26'h0, 26'h0, 0, 0, 1);       // read hit
        tbl[2]  = mk(0, 1, 26'h1000012, 3, 0, 2, 0, 0, 26'h0, 26'h0, 0, 1, 0);       // write miss, clean victim
        tbl[3]  = mk(1, 0, 26'h2000012, 2, 0, 6, 2, 2, 26'h2000012, 26'h1000012, 1, 0, 3); // dirty victim
        tbl[4]  = mk(1, 1, 26'h0000034, 3, 0, 2, 0, 0, 26'h0, 26'h0, 0, 1, 0);       // rd+wr -> write
        tbl[5]  = mk(1, 0, 26'h0000034, 3, 0, 2, 0, 0, 26'h0, 26'h0, 0, 0, 1);       // hit on written line
        tbl[6]  = mk(0, 1, 26'h3000034, 1, 0, 3, 0, 1, 26'h0, 26'h0000034, 0, 1, 1); // write miss, dirty victim
        tbl[7]  = mk(1, 0, 26'h00000FF, 1, 0, 3, 1, 0, 26'h00000FF, 26'h0, 1, 0, 1); // set 255
        tbl[8]  = mk(0, 1, 26'h3FFFF00, 1, 0, 2, 0, 0, 26'h0, 26'h0, 0, 1, 0);       // set 0, max tag
        tbl[9]  = mk(1, 0, 26'h3FFFF00, 1, 0, 2, 0, 0, 26'h0, 26'h0, 0, 0, 1);
        tbl[10] = mk(1, 0, 26'h00000FF, 1, 0, 2, 0, 0, 26'h0, 26'h0, 0, 0, 1);
        tbl[11] = mk(1, 0, 26'h0000056, 3, 1, 5, 3, 0, 26'h0000056, 26'h0, 1, 0, 1); // request dropped

        l2.read_L1_L2   = 1'b0;
        l2.write_L1_L2  = 1'b0;
        l2.blk_addr     = '0;
        l2.ready_MEM_L2 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", all_outs(), 64'd0);

        for (int i = 0; i < 12; i++) begin
            run(i, tbl[i]);
        end

        // Stray memory ack while idle must be ignored
        l2.ready_MEM_L2 = 1'b1;
        #1;
        chk("stray_mem_ack_refill", 64'(l2.refill_L2), 64'd0);
        @(posedge clk);
        #1;
        l2.ready_MEM_L2 = 1'b0;
        chk("stray_mem_ack_idle", all_outs(), 64'd0);
        run(12, mk(1, 0, 26'h0000056, 3, 0, 2, 0, 0, 26'h0, 26'h0, 0, 0, 1));

        // Reset in the middle of a line fetch aborts it without an ack
        l2.read_L1_L2 = 1'b1;
        l2.blk_addr   = 26'h0000078;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk);
            #1;
            if (l2.read_L2_MEM) found = 1'b1;
        end
        chk("rst_seq_reached_allocate", 64'(found), 64'd1);
        rst = 1'b1;
        l2.read_L1_L2 = 1'b0;
        #1;
        chk("rst_seq_outputs_cleared", all_outs(), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (l2.ready_L2_L1 || l2.busy) stray++;
        end
        chk("rst_seq_no_ack", 64'(stray), 64'd0);
        run(13, mk(1, 0, 26'h0000056, 3, 0, 5, 3, 0, 26'h0000056, 26'h0, 1, 0, 1));
        run(14, mk(1, 0, 26'h0000078, 1, 0, 3, 1, 0, 26'h0000078, 26'h0, 1, 0, 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
